// File: rtl/pif_ram_if.sv
// Bus bundle between the PIF serial interface / PIF CPU (master) and pif_ram_arbiter (slave).
interface pif_ram_if #(parameter int ADDR_W = 9);
  logic [ADDR_W-1:0] n64_address;
  logic              n64_wren;
  logic [31:0]       n64_data_in;
  logic [31:0]       n64_data_out;
  logic [ADDR_W+1:0] cpu_address;
  logic              cpu_wren;
  logic              cpu_oe;
  logic [7:0]        cpu_data_in;
  logic [7:0]        cpu_data_out;
  logic              cpu_valid;
  logic              cpu_busy;
  logic              cpu_irq_clear;
  logic              cmd_irq;
  logic              protect_err;

  modport slave (
    input  n64_address, n64_wren, n64_data_in, cpu_address, cpu_wren, cpu_oe,
           cpu_data_in, cpu_irq_clear,
    output n64_data_out, cpu_data_out, cpu_valid, cpu_busy, cmd_irq, protect_err
  );

  modport master (
    output n64_address, n64_wren, n64_data_in, cpu_address, cpu_wren, cpu_oe,
           cpu_data_in, cpu_irq_clear,
    input  n64_data_out, cpu_data_out, cpu_valid, cpu_busy, cmd_irq, protect_err
  );
endinterface

// File: rtl/pif_ram_arbiter.sv
// PIF RAM: 32-bit N64 word port with write priority, byte read-modify-write CPU port, command IRQ.
// Optional feature macro PIF_ROM_PROTECT_EN: N64 writes below ROM_WORDS are dropped and flagged.
module pif_ram_arbiter #(
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] CMD_WORD  = 9'h0F,
  parameter int                ROM_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  pif_ram_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] WRITE_PEND = 1'b1;

`ifdef PIF_ROM_PROTECT_EN
  localparam logic PROTECT_ON = 1'b1;
`else
  localparam logic PROTECT_ON = 1'b0;
`endif

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] sel,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (sel)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      2'd3:    w[7:0]   = b;
      default: w = word;
    endcase
    return w;
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [0:0]        state_r;
  logic [ADDR_W+1:0] pend_addr_r;
  logic [7:0]        pend_data_r;
  logic [31:0]       n64_data_out_r;
  logic [7:0]        cpu_data_out_r;
  logic              cpu_valid_r;
  logic              cmd_irq_r;
  logic              protect_err_r;

  logic              prot_hit_s;
  logic              n64_accept_s;
  logic              cpu_commit_s;
  logic              cpu_rd_s;
  logic              irq_set_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [31:0]       wr_data_s;
  logic [ADDR_W-1:0] cpu_word_s;
  logic [ADDR_W-1:0] pend_word_s;
  logic [31:0]       cpu_word_data_s;

  assign cpu_word_s  = bus.cpu_address[ADDR_W+1:2];
  assign pend_word_s = pend_addr_r[ADDR_W+1:2];

  // Write-port arbitration, CPU read forwarding and request decode
  always_comb begin
    prot_hit_s   = PROTECT_ON && (32'(bus.n64_address) < 32'(ROM_WORDS));
    n64_accept_s = bus.n64_wren && !prot_hit_s;
    cpu_commit_s = (state_r == WRITE_PEND) && !bus.n64_wren;
    cpu_rd_s     = (state_r == IDLE) && bus.cpu_oe && !bus.cpu_wren;
    irq_set_s    = n64_accept_s && (bus.n64_address == CMD_WORD);
    wr_en_s      = 1'b0;
    wr_addr_s    = pend_word_s;
    wr_data_s    = 32'h0000_0000;
    if (n64_accept_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = bus.n64_address;
      wr_data_s = bus.n64_data_in;
    end else if (cpu_commit_s) begin
      // Merge against the word as it stands now, so earlier N64 writes survive
      wr_en_s   = 1'b1;
      wr_addr_s = pend_word_s;
      wr_data_s = put_byte(mem_r[pend_word_s], pend_addr_r[1:0], pend_data_r);
    end else begin
      wr_en_s   = 1'b0;
    end
    if (n64_accept_s && (bus.n64_address == cpu_word_s)) begin
      cpu_word_data_s = bus.n64_data_in;
    end else begin
      cpu_word_data_s = mem_r[cpu_word_s];
    end
  end

  // Storage array: single write port, contents not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Registered read data, CPU write FSM and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      pend_addr_r    <= '0;
      pend_data_r    <= 8'h00;
      n64_data_out_r <= 32'h0000_0000;
      cpu_data_out_r <= 8'h00;
      cpu_valid_r    <= 1'b0;
      cmd_irq_r      <= 1'b0;
      protect_err_r  <= 1'b0;
    end else begin
      n64_data_out_r <= mem_r[bus.n64_address];
      cpu_valid_r    <= cpu_rd_s;
      cpu_data_out_r <= cpu_rd_s ? get_byte(cpu_word_data_s, bus.cpu_address[1:0]) : 8'h00;
      case (state_r)
        IDLE: begin
          if (bus.cpu_wren) begin
            state_r     <= WRITE_PEND;
            pend_addr_r <= bus.cpu_address;
            pend_data_r <= bus.cpu_data_in;
          end
        end
        WRITE_PEND: begin
          if (!bus.n64_wren) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (irq_set_s) begin
        cmd_irq_r <= 1'b1;
      end else if (bus.cpu_irq_clear) begin
        cmd_irq_r <= 1'b0;
      end
      if (bus.n64_wren && prot_hit_s) begin
        protect_err_r <= 1'b1;
      end
    end
  end

  assign bus.n64_data_out = n64_data_out_r;
  assign bus.cpu_data_out = cpu_data_out_r;
  assign bus.cpu_valid    = cpu_valid_r;
  assign bus.cpu_busy     = (state_r == WRITE_PEND);
  assign bus.cmd_irq      = cmd_irq_r;
  assign bus.protect_err  = protect_err_r;
endmodule

// File: tb/tb_pif_ram_arbiter.sv
// Self-checking bench for pif_ram_arbiter: directed vector table, randomized model run, reset abort.
module tb_pif_ram_arbiter;
  localparam int         ADDR_W    = 9;
  localparam logic [8:0] CMD_WORD  = 9'h00F;
  localparam int         ROM_WORDS = 16;
`ifdef PIF_ROM_PROTECT_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  pif_ram_if #(.ADDR_W(ADDR_W)) bus ();

  pif_ram_arbiter #(.ADDR_W(ADDR_W), .CMD_WORD(CMD_WORD), .ROM_WORDS(ROM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  n_addr;
    logic        n_wren;
    logic [31:0] n_din;
    logic [10:0] c_addr;
    logic        c_wren;
    logic        c_oe;
    logic [7:0]  c_din;
    logic        clr;
    logic [31:0] e_n64;
    logic [31:0] e_mask;
    logic        e_valid;
    logic [7:0]  e_cdata;
    logic        e_busy;
    logic        e_irq;
    logic        e_perr;
  } vec_t;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } pend_t;

  vec_t        vt [21];
  logic [31:0] m_mem [512];
  logic [3:0]  m_vb [512];
  pend_t       m_pend [$];
  logic        m_irq;
  logic        m_perr;
  logic [31:0] e_n64;
  logic [31:0] e_mask;
  logic        e_valid;
  logic [7:0]  e_cdata;
  logic [7:0]  e_cmask;
  logic        e_busy;

  function automatic vec_t mk(input logic [8:0] na, input logic nw, input logic [31:0] nd,
                              input logic [10:0] ca, input logic cw, input logic co,
                              input logic [7:0] cd, input logic cl, input logic [31:0] en,
                              input logic [31:0] em, input logic ev, input logic [7:0] ec,
                              input logic eb, input logic ei, input logic ep);
    vec_t v;
    v.n_addr = na; v.n_wren = nw; v.n_din = nd; v.c_addr = ca; v.c_wren = cw; v.c_oe = co;
    v.c_din = cd; v.clr = cl; v.e_n64 = en; v.e_mask = em; v.e_valid = ev; v.e_cdata = ec;
    v.e_busy = eb; v.e_irq = ei; v.e_perr = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] mask);
    if (mask != 32'h0) begin
      checks++;
      if ((act & mask) !== (exp & mask)) begin
        failures++;
        $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
      end
    end
  endtask

  task automatic drive(input logic [8:0] na, input logic nw, input logic [31:0] nd,
                       input logic [10:0] ca, input logic cw, input logic co,
                       input logic [7:0] cd, input logic cl);
    bus.n64_address = na; bus.n64_wren = nw; bus.n64_data_in = nd;
    bus.cpu_address = ca; bus.cpu_wren = cw; bus.cpu_oe = co;
    bus.cpu_data_in = cd; bus.cpu_irq_clear = cl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".n64_data_out"}, bus.n64_data_out, 32'h0, 32'hFFFF_FFFF);
    check({tag, ".cpu_data_out"}, {24'h0, bus.cpu_data_out}, 32'h0, 32'h0000_00FF);
    check({tag, ".cpu_valid"}, {31'h0, bus.cpu_valid}, 32'h0, 32'h1);
    check({tag, ".cpu_busy"}, {31'h0, bus.cpu_busy}, 32'h0, 32'h1);
    check({tag, ".cmd_irq"}, {31'h0, bus.cmd_irq}, 32'h0, 32'h1);
    check({tag, ".protect_err"}, {31'h0, bus.protect_err}, 32'h0, 32'h1);
  endtask

  // Reference: one clock edge applied to the current inputs, written as word/byte arithmetic
  task automatic model_edge();
    logic [8:0]  a;
    logic [8:0]  w;
    logic        acc;
    logic        busy;
    logic [31:0] word;
    logic [3:0]  vb;
    int          idx;
    pend_t       p;
    a    = bus.n64_address;
    busy = (m_pend.size() != 0);
    acc  = bus.n64_wren && !(PROT && (a < 9'(ROM_WORDS)));
    e_n64  = m_mem[a];
    e_mask = {{8{m_vb[a][3]}}, {8{m_vb[a][2]}}, {8{m_vb[a][1]}}, {8{m_vb[a][0]}}};
    w       = bus.cpu_address[10:2];
    e_valid = !busy && bus.cpu_oe && !bus.cpu_wren;
    e_cdata = 8'h00;
    e_cmask = 8'hFF;
    if (e_valid) begin
      if (acc && (a == w)) begin
        word = bus.n64_data_in; vb = 4'hF;
      end else begin
        word = m_mem[w]; vb = m_vb[w];
      end
      idx     = 3 - int'(bus.cpu_address[1:0]);
      e_cdata = 8'(word >> (8 * idx));
      e_cmask = vb[idx] ? 8'hFF : 8'h00;
    end
    if (busy && !bus.n64_wren) begin
      p   = m_pend.pop_front();
      w   = p.addr[10:2];
      idx = 3 - int'(p.addr[1:0]);
      m_mem[w] = (m_mem[w] & ~(32'hFF << (8 * idx))) | (32'(p.data) << (8 * idx));
      m_vb[w][idx] = 1'b1;
    end else if (!busy && bus.cpu_wren) begin
      p.addr = bus.cpu_address;
      p.data = bus.cpu_data_in;
      m_pend.push_back(p);
    end
    if (acc) begin
      m_mem[a] = bus.n64_data_in;
      m_vb[a]  = 4'hF;
    end
    if (acc && (a == CMD_WORD)) m_irq = 1'b1;
    else if (bus.cpu_irq_clear) m_irq = 1'b0;
    if (bus.n64_wren && !acc) m_perr = 1'b1;
    e_busy = (m_pend.size() != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fm;
    fm = PROT ? 32'h0 : 32'hFFFF_FFFF;
    vt[0]  = mk(9'h020, 1'b1, 32'h1122_3344, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vt[1]  = mk(9'h020, 1'b0, 32'h0, 11'h081, 1'b0, 1'b1, 8'h00, 1'b0, 32'h1122_3344, 32'hFFFF_FFFF, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    vt[2]  = mk(9'h021, 1'b1, 32'hAABB_CCDD, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vt[3]  = mk(9'h021, 1'b0, 32'h0, 11'h086, 1'b1, 1'b0, 8'h55, 1'b0, 32'hAABB_CCDD, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[4]  = mk(9'h021, 1'b1, 32'h0102_0304, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'hAABB_CCDD, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[5]  = mk(9'h021, 1'b1, 32'h0102_0304, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0102_0304, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[6]  = mk(9'h021, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0102_0304, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vt[7]  = mk(9'h021, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0102_5504, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vt[8]  = mk(9'h021, 1'b0, 32'h0, 11'h084, 1'b1, 1'b0, 8'h99, 1'b0, 32'h0102_5504, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[9]  = mk(9'h022, 1'b1, 32'hCAFE_F00D, 11'h085, 1'b1, 1'b1, 8'h77, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[10] = mk(9'h021, 1'b0, 32'h0, 11'h084, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0102_5504, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vt[11] = mk(9'h021, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h9902_5504, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vt[12] = mk(9'h022, 1'b0, 32'h0, 11'h085, 1'b0, 1'b1, 8'h00, 1'b0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    vt[13] = mk(CMD_WORD, 1'b1, 32'h1234_5678, 11'h000, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, !PROT, PROT);
    vt[14] = mk(CMD_WORD, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h1234_5678, fm, 1'b0, 8'h00, 1'b0, !PROT, PROT);
    vt[15] = mk(CMD_WORD, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b1, 32'h1234_5678, fm, 1'b0, 8'h00, 1'b0, 1'b0, PROT);
    vt[16] = mk(9'h020, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, PROT);
    vt[17] = mk(9'h005, 1'b0, 32'h0, 11'h014, 1'b1, 1'b0, 8'hA5, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0, PROT);
    vt[18] = mk(9'h005, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, PROT);
    vt[19] = mk(9'h005, 1'b1, 32'hDEAD_BEEF, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0, 32'hA500_0000, 32'hFF00_0000, 1'b0, 8'h00, 1'b0, 1'b0, PROT);
    vt[20] = mk(9'h005, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0,
                PROT ? 32'hA500_0000 : 32'hDEAD_BEEF, PROT ? 32'hFF00_0000 : 32'hFFFF_FFFF,
                1'b0, 8'h00, 1'b0, 1'b0, PROT);

    reset = 1'b1;
    drive(9'h000, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;

    // Directed vectors: outputs checked one edge after each row is applied
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].n_addr, vt[i].n_wren, vt[i].n_din, vt[i].c_addr, vt[i].c_wren, vt[i].c_oe,
            vt[i].c_din, vt[i].clr);
      step();
      check($sformatf("vec%0d.n64_data_out", i), bus.n64_data_out, vt[i].e_n64, vt[i].e_mask);
      check($sformatf("vec%0d.cpu_valid", i), {31'h0, bus.cpu_valid}, {31'h0, vt[i].e_valid}, 32'h1);
      check($sformatf("vec%0d.cpu_data_out", i), {24'h0, bus.cpu_data_out}, {24'h0, vt[i].e_cdata}, 32'hFF);
      check($sformatf("vec%0d.cpu_busy", i), {31'h0, bus.cpu_busy}, {31'h0, vt[i].e_busy}, 32'h1);
      check($sformatf("vec%0d.cmd_irq", i), {31'h0, bus.cmd_irq}, {31'h0, vt[i].e_irq}, 32'h1);
      check($sformatf("vec%0d.protect_err", i), {31'h0, bus.protect_err}, {31'h0, vt[i].e_perr}, 32'h1);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 512; i++) begin
      m_mem[i] = 32'h0;
      m_vb[i]  = 4'h0;
    end
    m_irq  = 1'b0;
    m_perr = PROT;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) == 0) ? CMD_WORD : 9'(32'h40 + $urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), $urandom,
            11'(32'h100 + $urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0), 8'($urandom), ($urandom_range(0, 7) == 0));
      model_edge();
      step();
      check("rnd.n64_data_out", bus.n64_data_out, e_n64, e_mask);
      check("rnd.cpu_valid", {31'h0, bus.cpu_valid}, {31'h0, e_valid}, 32'h1);
      check("rnd.cpu_data_out", {24'h0, bus.cpu_data_out}, {24'h0, e_cdata}, {24'h0, e_cmask});
      check("rnd.cpu_busy", {31'h0, bus.cpu_busy}, {31'h0, e_busy}, 32'h1);
      check("rnd.cmd_irq", {31'h0, bus.cmd_irq}, {31'h0, m_irq}, 32'h1);
      check("rnd.protect_err", {31'h0, bus.protect_err}, {31'h0, m_perr}, 32'h1);
    end

    // Reset while a CPU write is pending: byte discarded, memory untouched
    drive(9'h000, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    drive(CMD_WORD, 1'b1, 32'h0000_0001, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    drive(9'h030, 1'b1, 32'h0BAD_CAFE, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    drive(9'h030, 1'b0, 32'h0, 11'h0C1, 1'b1, 1'b0, 8'h11, 1'b0);
    step();
    drive(9'h031, 1'b1, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check("abort.busy_before", {31'h0, bus.cpu_busy}, 32'h1, 32'h1);
    check("abort.irq_before", {31'h0, bus.cmd_irq}, {31'h0, !PROT}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("abort.in_reset");
    drive(9'h030, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    reset = 1'b0;
    drive(9'h030, 1'b0, 32'h0, 11'h0C1, 1'b0, 1'b1, 8'h00, 1'b0);
    step();
    check("abort.word", bus.n64_data_out, 32'h0BAD_CAFE, 32'hFFFF_FFFF);
    check("abort.cpu_valid", {31'h0, bus.cpu_valid}, 32'h1, 32'h1);
    check("abort.cpu_byte", {24'h0, bus.cpu_data_out}, 32'h0000_00AD, 32'hFF);
    check("abort.busy_after", {31'h0, bus.cpu_busy}, 32'h0, 32'h1);
    drive(9'h030, 1'b0, 32'h0, 11'h000, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check("abort.word_later", bus.n64_data_out, 32'h0BAD_CAFE, 32'hFFFF_FFFF);
    check("abort.valid_drop", {31'h0, bus.cpu_valid}, 32'h0, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
